// File: rtl/spi_master_mc_pkg.sv
// Shared definitions for the spi_master_mc SPI master: register addresses,
// STATUS/CTRL bit positions, SPI mode encodings and FSM state type.
package spi_master_mc_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_TXDATA = 4'h1;
    localparam logic [3:0] ADDR_RXDATA = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h3;
    localparam logic [3:0] ADDR_DIV    = 4'h4;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_IRQ_PEND = 3;

    localparam int CTRL_CPHA      = 0;
    localparam int CTRL_CPOL      = 1;
    localparam int CTRL_SS_EN     = 2;
    localparam int CTRL_SS_SEL_LO = 3;
    localparam int CTRL_SS_SEL_HI = 4;
    localparam int CTRL_IRQ_EN    = 5;

    // Encoded as {CPOL, CPHA}, matching CTRL[1:0].
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    function automatic int reset_div(input int clk_freq, input int sclk_freq);
        return clk_freq / (2 * sclk_freq) - 1;
    endfunction

endpackage

// File: rtl/spi_master_mc_if.sv
// CPU register-bus port of spi_master_mc: one-cycle access strobe, 4-bit
// address, 8-bit write data and registered 8-bit read data.
interface spi_master_mc_if;

    logic       i_en;
    logic       i_wr;
    logic [3:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;

    // Bus protocol: an access happens on every clock edge where i_en is high
    // (no backpressure); i_wr selects write, and read data appears on o_data
    // the cycle after the access and holds until the next read.
    modport master (
        output i_en,
        output i_wr,
        output i_addr,
        output i_data,
        input  o_data
    );

    modport slave (
        input  i_en,
        input  i_wr,
        input  i_addr,
        input  i_data,
        output o_data
    );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: 8-bit down-counter that emits a one-cycle tick
// every i_div+1 enabled cycles; i_load restarts the count from i_div.
module spi_clk_div (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [7:0] i_div,
    output logic       o_tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_div;
        end else if (i_en) begin
            cnt_d = (cnt_q == 8'd0) ? i_div : cnt_q - 8'd1;
        end
    end

    assign o_tick = i_en && !i_load && (cnt_q == 8'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-mode, multi-slave byte SPI master on the CPU register bus.
// Optional transfer-done interrupt (o_irq, IRQ_EN, irq_pend) enabled by SPI_IRQ_EN.
module spi_master_mc
    import spi_master_mc_pkg::*;
#(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int SCLK_FREQ = 1_000_000,
    parameter int NUM_SS    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    spi_master_mc_if.slave    bus,
    output logic              o_SCLK,
    output logic              o_MOSI,
    input  logic              i_MISO,
    output logic [NUM_SS-1:0] o_SS
`ifdef SPI_IRQ_EN
    ,
    output logic              o_irq
`endif
);

    localparam int         RESET_DIV   = reset_div(CLK_FREQ, SCLK_FREQ);
    localparam logic [7:0] RESET_DIV_8 = 8'(RESET_DIV);

    if (RESET_DIV > 255 || RESET_DIV < 0) begin : g_bad_div
        $error("spi_master_mc: reset divisor out of 0..255 range");
    end
    if (NUM_SS < 1 || NUM_SS > 4) begin : g_bad_num_ss
        $error("spi_master_mc: NUM_SS must be in 1..4");
    end

    spi_state_e        state_q, state_d;
    logic [5:0]        ctrl_q, ctrl_d;
    logic [7:0]        div_q, div_d;
    logic [7:0]        tx_sh_q, tx_sh_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              irq_pend_q, irq_pend_d;
    logic [3:0]        edge_cnt_q, edge_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_SS-1:0] ss_q, ss_d;
    logic [7:0]        rdata_q, rdata_d;
`ifdef SPI_IRQ_EN
    logic              irq_q, irq_d;
`endif

    logic busy;
    logic rd_en;
    logic wr_en;
    logic start;
    logic tick;
    logic cpha;
    logic ctrl_irq_bit;

    assign busy  = (state_q != ST_IDLE);
    assign rd_en = bus.i_en && !bus.i_wr;
    assign wr_en = bus.i_en && bus.i_wr;
    assign start = wr_en && !busy && (bus.i_addr == ADDR_TXDATA);
    assign cpha  = ctrl_q[CTRL_CPHA];

`ifdef SPI_IRQ_EN
    assign ctrl_irq_bit = bus.i_data[CTRL_IRQ_EN];
`else
    assign ctrl_irq_bit = 1'b0;
`endif

    spi_clk_div u_clk_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (start),
        .i_en   (busy),
        .i_div  (div_q),
        .o_tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        div_d      = div_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        irq_pend_d = irq_pend_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rdata_d    = rdata_q;

        if (rd_en) begin
            case (bus.i_addr)
                ADDR_STATUS: rdata_d = {4'b0000, irq_pend_q, overrun_q, rx_valid_q, busy};
                ADDR_RXDATA: rdata_d = rx_data_q;
                ADDR_CTRL:   rdata_d = {2'b00, ctrl_q};
                ADDR_DIV:    rdata_d = div_q;
                default:     rdata_d = 8'h00;
            endcase
            if (bus.i_addr == ADDR_STATUS) begin
                overrun_d  = 1'b0;
                irq_pend_d = 1'b0;
            end
            if (bus.i_addr == ADDR_RXDATA) begin
                rx_valid_d = 1'b0;
            end
        end

        // Configuration is frozen while a byte is on the wire.
        if (wr_en && !busy) begin
            if (bus.i_addr == ADDR_CTRL) begin
                ctrl_d = {ctrl_irq_bit, bus.i_data[4:0]};
            end
            if (bus.i_addr == ADDR_DIV) begin
                div_d = bus.i_data;
            end
        end
        if (wr_en && busy && (bus.i_addr == ADDR_TXDATA)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                sclk_d = ctrl_d[CTRL_CPOL];
                if (start) begin
                    state_d    = ST_LEAD;
                    edge_cnt_d = 4'd0;
                    tx_sh_d    = bus.i_data;
                    // CPHA=0 slaves sample on the first edge, so the MSB must already be out.
                    if (!cpha) begin
                        mosi_d  = bus.i_data[7];
                        tx_sh_d = {bus.i_data[6:0], 1'b0};
                    end
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d     = !sclk_q;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    // edge_cnt_q even means this is an odd (1st, 3rd, ...) edge.
                    if ((!edge_cnt_q[0]) ^ cpha) begin
                        rx_sh_d = {rx_sh_q[6:0], i_MISO};
                    end else begin
                        mosi_d  = tx_sh_q[7];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                    if (edge_cnt_q == 4'd15) begin
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d    = ST_IDLE;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    if (rx_valid_q) begin
                        overrun_d = 1'b1;
                    end
`ifdef SPI_IRQ_EN
                    irq_pend_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ss_d = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ctrl_d[CTRL_SS_EN] && (ctrl_d[CTRL_SS_SEL_HI:CTRL_SS_SEL_LO] == 2'(i))) begin
                ss_d[i] = 1'b0;
            end
        end
    end

`ifdef SPI_IRQ_EN
    assign irq_d = irq_pend_d & ctrl_d[CTRL_IRQ_EN];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 6'h00;
            div_q      <= RESET_DIV_8;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            irq_pend_q <= 1'b0;
            edge_cnt_q <= 4'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_q       <= '1;
            rdata_q    <= 8'h00;
`ifdef SPI_IRQ_EN
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            irq_pend_q <= irq_pend_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            rdata_q    <= rdata_d;
`ifdef SPI_IRQ_EN
            irq_q      <= irq_d;
`endif
        end
    end

    assign bus.o_data = rdata_q;
    assign o_SCLK     = sclk_q;
    assign o_MOSI     = mosi_q;
    assign o_SS       = ss_q;
`ifdef SPI_IRQ_EN
    assign o_irq      = irq_q;
`endif

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc (NUM_SS = 4): register reset values, all four
// SPI modes, overrun, slave selects, mid-transfer reset and, with SPI_IRQ_EN, o_irq.
module tb_spi_master_mc;
    import spi_master_mc_pkg::*;

    localparam int NUM_SS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_mc_if bus_if ();

    logic              sclk;
    logic              mosi;
    logic [NUM_SS-1:0] ss;
    logic              loopback;
    logic              slave_miso;
    wire               miso = loopback ? mosi : slave_miso;
`ifdef SPI_IRQ_EN
    logic              irq;
`endif

    spi_master_mc #(.NUM_SS(NUM_SS)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bus_if),
        .o_SCLK (sclk),
        .o_MOSI (mosi),
        .i_MISO (miso),
        .o_SS   (ss)
`ifdef SPI_IRQ_EN
        ,
        .o_irq  (irq)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.i_en   = 1'b1;
        bus_if.i_wr   = 1'b1;
        bus_if.i_addr = a;
        bus_if.i_data = d;
        @(negedge clk);
        bus_if.i_en   = 1'b0;
        bus_if.i_wr   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.i_en   = 1'b1;
        bus_if.i_wr   = 1'b0;
        bus_if.i_addr = a;
        @(negedge clk);
        bus_if.i_en   = 1'b0;
        d = bus_if.o_data;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check8(tag, d, exp);
    endtask

    // Starts a transfer and polls STATUS every cycle until busy drops, acting as
    // a slave that returns 0x3C and captures MOSI on the sample edges for cpha.
    task automatic run_xfer(input logic [7:0] tx, input logic cpha,
                            output int busy_n, output int edges, output int rises,
                            output int min_gap, output int max_gap,
                            output logic [7:0] srx, output logic [7:0] last_st);
        logic [7:0] stx;
        logic [7:0] st;
        logic       prev_sclk;
        int         bitn;
        int         last_t;
        stx = 8'h3C;
        srx = 8'h00;
        if (!cpha) begin
            slave_miso = stx[7];
            bitn = 6;
        end else begin
            bitn = 7;
        end
        bus_write(ADDR_TXDATA, tx);
        bus_if.i_en   = 1'b1;
        bus_if.i_wr   = 1'b0;
        bus_if.i_addr = ADDR_STATUS;
        prev_sclk = sclk;
        busy_n  = 0;
        edges   = 0;
        rises   = 0;
        min_gap = 1000;
        max_gap = 0;
        last_t  = -1;
        last_st = 8'hFF;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            st = bus_if.o_data;
            if (sclk !== prev_sclk) begin
                edges++;
                if (sclk) rises++;
                if (last_t >= 0) begin
                    if (t - last_t < min_gap) min_gap = t - last_t;
                    if (t - last_t > max_gap) max_gap = t - last_t;
                end
                last_t = t;
                if (edges[0] ^ cpha) begin
                    srx = {srx[6:0], mosi};
                end else if (bitn >= 0) begin
                    slave_miso = stx[bitn];
                    bitn--;
                end
                prev_sclk = sclk;
            end
            if (st[0]) begin
                busy_n++;
            end else begin
                last_st = st;
                break;
            end
        end
        bus_if.i_en = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         busy_n, edges, rises, min_gap, max_gap;
        logic [7:0] srx, st;
        logic [7:0] tx_vec [4];
        tx_vec[0] = 8'hA5;
        tx_vec[1] = 8'h96;
        tx_vec[2] = 8'h5B;
        tx_vec[3] = 8'hE1;

        rst           = 1'b1;
        bus_if.i_en   = 1'b0;
        bus_if.i_wr   = 1'b0;
        bus_if.i_addr = 4'h0;
        bus_if.i_data = 8'h00;
        loopback      = 1'b1;
        slave_miso    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check8("reset_ss", {4'b0000, ss}, 8'h0F);
        check8("reset_sclk", {7'b0, sclk}, 8'h00);
        check8("reset_mosi", {7'b0, mosi}, 8'h00);
        check8("reset_odata", bus_if.o_data, 8'h00);
        check_reg("reset_status", ADDR_STATUS, 8'h00);
        check_reg("reset_ctrl", ADDR_CTRL, 8'h00);
        check_reg("reset_div", ADDR_DIV, 8'h17);
        check_reg("reset_rxdata", ADDR_RXDATA, 8'h00);
        check_reg("unmapped_read", 4'h7, 8'h00);
        bus_write(4'h9, 8'hFF);
        check_reg("unmapped_write_ctrl", ADDR_CTRL, 8'h00);

        // Mode 0, DIV = 0, loopback
        bus_write(ADDR_DIV, 8'h00);
        bus_write(ADDR_CTRL, 8'h04);
        check8("m0_ss", {4'b0000, ss}, 8'h0E);
        run_xfer(tx_vec[0], 1'b0, busy_n, edges, rises, min_gap, max_gap, srx, st);
        checki("m0_busy_cycles", busy_n, 18);
        checki("m0_edges", edges, 16);
        checki("m0_rises", rises, 8);
        checki("m0_min_gap", min_gap, 1);
        checki("m0_max_gap", max_gap, 1);
        check8("m0_slave_rx", srx, 8'hA5);
        check8("m0_status_done", st, 8'h02);
        check8("m0_sclk_idle", {7'b0, sclk}, 8'h00);
        check_reg("m0_rxdata", ADDR_RXDATA, 8'hA5);
        check_reg("m0_status_after_rd", ADDR_STATUS, 8'h00);

        // Modes 1..3, DIV = 3, slave returns 0x3C
        loopback = 1'b0;
        bus_write(ADDR_DIV, 8'h03);
        for (int m = 1; m < 4; m++) begin
            bus_write(ADDR_CTRL, 8'h04 | 8'(m));
            check8($sformatf("m%0d_sclk_idle", m), {7'b0, sclk}, {7'b0, m[1]});
            run_xfer(tx_vec[m], m[0], busy_n, edges, rises, min_gap, max_gap, srx, st);
            checki($sformatf("m%0d_busy_cycles", m), busy_n, 72);
            checki($sformatf("m%0d_edges", m), edges, 16);
            checki($sformatf("m%0d_rises", m), rises, 8);
            checki($sformatf("m%0d_min_gap", m), min_gap, 4);
            checki($sformatf("m%0d_max_gap", m), max_gap, 4);
            check8($sformatf("m%0d_slave_rx", m), srx, tx_vec[m]);
            check8($sformatf("m%0d_status_done", m), st, 8'h02);
            check8($sformatf("m%0d_sclk_after", m), {7'b0, sclk}, {7'b0, m[1]});
            check_reg($sformatf("m%0d_rxdata", m), ADDR_RXDATA, 8'h3C);
        end

        // Overrun from TXDATA write while busy; CTRL/DIV frozen while busy
        loopback = 1'b1;
        bus_write(ADDR_CTRL, 8'h04);
        bus_write(ADDR_TXDATA, 8'h11);
        bus_write(ADDR_TXDATA, 8'h22);
        bus_write(ADDR_DIV, 8'h55);
        bus_write(ADDR_CTRL, 8'h07);
        repeat (80) @(negedge clk);
        check_reg("ovr_status_set", ADDR_STATUS, 8'h06);
        check_reg("ovr_status_clr", ADDR_STATUS, 8'h02);
        check_reg("busy_div_ignored", ADDR_DIV, 8'h03);
        check_reg("busy_ctrl_ignored", ADDR_CTRL, 8'h04);
        check_reg("ovr_rxdata", ADDR_RXDATA, 8'h11);

        // Completion with rx_valid already set
        bus_write(ADDR_TXDATA, 8'h5A);
        repeat (80) @(negedge clk);
        check_reg("rxv_status_clean", ADDR_STATUS, 8'h02);
        bus_write(ADDR_TXDATA, 8'hC7);
        repeat (80) @(negedge clk);
        check_reg("rxv_status_ovr", ADDR_STATUS, 8'h06);
        check_reg("rxv_rxdata", ADDR_RXDATA, 8'hC7);

        // Slave selects
        bus_write(ADDR_CTRL, 8'h14);
        check8("ss_sel2_en", {4'b0000, ss}, 8'h0B);
        bus_write(ADDR_CTRL, 8'h18);
        check8("ss_sel3_dis", {4'b0000, ss}, 8'h0F);
        bus_write(ADDR_CTRL, 8'h1C);
        check8("ss_sel3_en", {4'b0000, ss}, 8'h07);
        bus_write(ADDR_CTRL, 8'hFF);
`ifdef SPI_IRQ_EN
        check_reg("ctrl_readback", ADDR_CTRL, 8'h3F);
`else
        check_reg("ctrl_readback", ADDR_CTRL, 8'h1F);
`endif
        check8("cpol1_sclk_idle", {7'b0, sclk}, 8'h01);
        bus_write(ADDR_CTRL, 8'h04);

        // Reset in the middle of SHIFT
        bus_write(ADDR_TXDATA, 8'h77);
        repeat (20) @(negedge clk);
        check8("mid_ss_active", {4'b0000, ss}, 8'h0E);
        rst = 1'b1;
        @(negedge clk);
        check8("rst_ss", {4'b0000, ss}, 8'h0F);
        check8("rst_sclk", {7'b0, sclk}, 8'h00);
        check8("rst_mosi", {7'b0, mosi}, 8'h00);
        check8("rst_odata", bus_if.o_data, 8'h00);
        rst = 1'b0;
        check_reg("rst_status", ADDR_STATUS, 8'h00);
        check_reg("rst_rxdata", ADDR_RXDATA, 8'h00);
        check_reg("rst_div", ADDR_DIV, 8'h17);

`ifdef SPI_IRQ_EN
        // Interrupt: pending without enable, then enabled
        bus_write(ADDR_DIV, 8'h00);
        bus_write(ADDR_CTRL, 8'h04);
        bus_write(ADDR_TXDATA, 8'h3A);
        repeat (30) @(negedge clk);
        check8("irq_masked", {7'b0, irq}, 8'h00);
        bus_write(ADDR_CTRL, 8'h24);
        check8("irq_late_enable", {7'b0, irq}, 8'h01);
        check_reg("irq_status_pend", ADDR_STATUS, 8'h0A);
        check8("irq_cleared_a", {7'b0, irq}, 8'h00);
        check_reg("irq_rx_a", ADDR_RXDATA, 8'h3A);
        bus_write(ADDR_TXDATA, 8'hC3);
        repeat (30) @(negedge clk);
        check8("irq_raised", {7'b0, irq}, 8'h01);
        check_reg("irq_rxdata", ADDR_RXDATA, 8'hC3);
        check8("irq_held_after_rx", {7'b0, irq}, 8'h01);
        check_reg("irq_status", ADDR_STATUS, 8'h08);
        check8("irq_cleared_b", {7'b0, irq}, 8'h00);
        check_reg("irq_status_after", ADDR_STATUS, 8'h00);
`else
        bus_write(ADDR_CTRL, 8'h24);
        check_reg("no_irq_ctrl_bit5", ADDR_CTRL, 8'h04);
        bus_write(ADDR_DIV, 8'h00);
        bus_write(ADDR_TXDATA, 8'h3A);
        repeat (30) @(negedge clk);
        check_reg("no_irq_status", ADDR_STATUS, 8'h02);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
